// File: rtl/axi3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi3_pkg
//  Description : Shared AXI3 types and constants for the write (and later
//                read) slave blocks: burst encoding, response codes, the
//                write-path state encoding and a WRAP-length legality helper.
//  Revision    : 1.0  initial release
// ============================================================================
package axi3_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    AW_ACK = 3'd1,
    W_WAIT = 3'd2,
    W_ACK  = 3'd3,
    B_RESP = 3'd4
  } wr_state_t;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi3_burst_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : axi3_burst_addr_gen
//  Description : Combinational next-beat address for an AXI3 burst.
//                FIXED keeps the address, INCR aligns then steps by the beat
//                size (wraps at ADDR_W bits), WRAP stays inside the aligned
//                window of size bytes*(len+1). Reserved burst type holds.
//  Ports       : addr_i      current beat byte address
//                size_i      log2(bytes per beat)
//                len_i       beats-1
//                burst_i     burst type
//                next_addr_o address of the following beat
//  Revision    : 1.0  initial release
// ============================================================================
module axi3_burst_addr_gen
  import axi3_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        size_i,
  input  logic [3:0]        len_i,
  input  burst_t            burst_i,
  output logic [ADDR_W-1:0] next_addr_o
);

  logic [ADDR_W-1:0] bytes_w;
  logic [ADDR_W-1:0] bound_w;

  always_comb begin
    bytes_w     = ADDR_W'(1) << size_i;
    bound_w     = bytes_w * (ADDR_W'(len_i) + ADDR_W'(1));
    next_addr_o = addr_i;
    case (burst_i)
      FIXED:   next_addr_o = addr_i;
      INCR:    next_addr_o = (addr_i & ~(bytes_w - ADDR_W'(1))) + bytes_w;
      WRAP:    next_addr_o = (addr_i & ~(bound_w - ADDR_W'(1))) |
                             ((addr_i + bytes_w) & (bound_w - ADDR_W'(1)));
      default: next_addr_o = addr_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/axi3_write_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi3_write_slave
//  Description : AXI3 write-path responder with one outstanding transaction.
//                Accepts an AW burst, absorbs W beats into a local byte-lane
//                memory and returns a B response. Every handshake output is a
//                register; each READY is a single-cycle pulse one cycle after
//                the matching VALID is seen.
//  Ports       : clk, reset             clock, synchronous active-high reset
//                AW* (ID/ADDR/LEN/SIZE/BURST/VALID/READY)  address channel
//                W*  (ID/DATA/STRB/LAST/VALID/READY)       data channel
//                B*  (ID/RESP/VALID/READY)                 response channel
//  Revision    : 1.0  initial release
// ============================================================================
module axi3_write_slave
  import axi3_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [3:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [ID_W-1:0]     WID,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int IDX_W    = $clog2(DEPTH);
  localparam int MAX_SIZE = $clog2(STRB_W);
  localparam logic [ADDR_W-1:0] BYTE_LIMIT = ADDR_W'(DEPTH * STRB_W);

  wr_state_t         state_q;
  logic              awready_q, wready_q, bvalid_q, err_q;
  logic [ID_W-1:0]   bid_q, awid_q;
  logic [1:0]        bresp_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        len_q;
  logic [2:0]        size_q;
  burst_t            burst_q;
  logic [4:0]        cnt_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              aw_illegal_w, beat_err_w, in_range_w, commit_w;
  logic [ADDR_W-1:0] aw_align_mask_w;
  logic [IDX_W-1:0]  word_idx_w;

  axi3_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (addr_d)
  );

  always_comb begin
    aw_align_mask_w = (ADDR_W'(1) << AWSIZE) - ADDR_W'(1);
    aw_illegal_w    = (AWBURST == RSVD) || (AWSIZE > 3'(MAX_SIZE)) ||
                      ((AWBURST == WRAP) &&
                       (!wrap_len_ok(AWLEN) || ((AWADDR & aw_align_mask_w) != '0)));
    in_range_w      = addr_q < BYTE_LIMIT;
    // A WLAST on any beat other than beat AWLEN (early or late) is an error.
    beat_err_w      = !in_range_w || (WID != awid_q) ||
                      (WLAST && (cnt_q != {1'b0, len_q}));
    // Once a burst is in error no further bytes land in memory, including
    // the beat that raised the error; surplus beats past AWLEN are dropped.
    commit_w        = !reset && (state_q == W_ACK) && !err_q && !beat_err_w &&
                      (cnt_q <= {1'b0, len_q});
    word_idx_w      = addr_q[IDX_W+MAX_SIZE-1:MAX_SIZE];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      awid_q    <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= FIXED;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (AWVALID) begin
            state_q   <= AW_ACK;
            awready_q <= 1'b1;
          end
        end
        AW_ACK: begin
          awready_q <= 1'b0;
          awid_q    <= AWID;
          addr_q    <= AWADDR;
          len_q     <= AWLEN;
          size_q    <= AWSIZE;
          burst_q   <= burst_t'(AWBURST);
          err_q     <= aw_illegal_w;
          cnt_q     <= '0;
          state_q   <= W_WAIT;
        end
        W_WAIT: begin
          if (WVALID) begin
            state_q  <= W_ACK;
            wready_q <= 1'b1;
          end
        end
        W_ACK: begin
          wready_q <= 1'b0;
          addr_q   <= addr_d;
          err_q    <= err_q | beat_err_w;
          // Saturate so an over-long burst can never alias back into range.
          if (cnt_q != 5'h1F) cnt_q <= cnt_q + 5'd1;
          if (WLAST) begin
            state_q  <= B_RESP;
            bvalid_q <= 1'b1;
            bid_q    <= awid_q;
            bresp_q  <= (err_q | beat_err_w) ? RESP_SLVERR : RESP_OKAY;
          end else begin
            state_q  <= W_WAIT;
          end
        end
        B_RESP: begin
          if (BREADY) begin
            state_q  <= IDLE;
            bvalid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage is deliberately not reset: data survives a reset mid-burst.
  always_ff @(posedge clk) begin
    if (commit_w) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (WSTRB[i]) mem_q[word_idx_w][8*i +: 8] <= WDATA[8*i +: 8];
      end
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;

endmodule
`default_nettype wire

// File: tb/tb_axi3_write_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi3_write_slave
//  Description : Directed bench for axi3_write_slave. A byte-level memory
//                model and a per-burst response model are computed from the
//                burst rules; a negedge process compares the B channel every
//                cycle and the memory is swept after every response.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi3_write_slave;

  logic        clk, reset;
  logic [3:0]  AWID, WID, BID;
  logic [31:0] AWADDR, WDATA;
  logic [3:0]  AWLEN, WSTRB;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST, BRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

  axi3_write_slave #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .DEPTH(256)) dut (
    .clk(clk), .reset(reset),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0]  exp_mem [1024];
  logic        mem_known    = 1'b0;
  logic        chk_en       = 1'b0;
  logic        model_bvalid = 1'b0;
  logic [3:0]  exp_bid      = '0;
  logic [1:0]  exp_bresp    = '0;

  // Beat table for the burst being driven.
  logic [31:0] bd [20];
  logic [3:0]  bs [20];
  logic [3:0]  bw [20];
  logic        bl [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] nxt(input logic [31:0] a, input logic [2:0] size,
                                      input logic [3:0] len, input logic [1:0] bt);
    logic [31:0] bytes, bound;
    bytes = 32'd1 << size;
    bound = bytes * (32'(len) + 32'd1);
    case (bt)
      2'b01:   return (a & ~(bytes - 1)) + bytes;
      2'b10:   return (a & ~(bound - 1)) | ((a + bytes) & (bound - 1));
      default: return a;
    endcase
  endfunction

  task automatic set_beats(input int nb, input logic [31:0] base,
                           input logic [3:0] strb, input logic [3:0] wid);
    for (int b = 0; b < 20; b++) begin
      bd[b] = base + 32'(b);
      bs[b] = strb;
      bw[b] = wid;
      bl[b] = (b == nb - 1);
    end
  endtask

  // Applies the burst to the byte model and yields the response it must get.
  task automatic model_apply(input logic [3:0] id, input logic [31:0] addr,
                             input logic [3:0] len, input logic [2:0] size,
                             input logic [1:0] bt, input int nb, output logic [1:0] resp);
    logic        err;
    logic [31:0] a;
    int          base;
    err = (bt == 2'b11) || (size > 3'd2) ||
          (bt == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
          (bt == 2'b10 && ((addr % (32'd1 << size)) != 0));
    a = addr;
    for (int b = 0; b < nb; b++) begin
      if (a >= 32'd1024 || bw[b] != id || (bl[b] && b != int'(len))) err = 1'b1;
      if (!err && b <= int'(len)) begin
        base = int'(a[9:2]) * 4;
        for (int i = 0; i < 4; i++)
          if (bs[b][i]) exp_mem[base + i] = bd[b][8*i +: 8];
      end
      a = nxt(a, size, len, bt);
    end
    resp = err ? 2'b10 : 2'b00;
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] bt);
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = bt; AWVALID = 1'b1;
    @(posedge clk); #1;
    chk("aw_ready_rise", 32'(AWREADY), 32'd1);
    @(posedge clk); #1;
    AWVALID = 1'b0;
    chk("aw_ready_fall", 32'(AWREADY), 32'd0);
  endtask

  task automatic do_w(input int b);
    WID = bw[b]; WDATA = bd[b]; WSTRB = bs[b]; WLAST = bl[b]; WVALID = 1'b1;
    @(posedge clk); #1;
    chk("w_ready_rise", 32'(WREADY), 32'd1);
    @(posedge clk); #1;
    WVALID = 1'b0; WLAST = 1'b0;
    chk("w_ready_fall", 32'(WREADY), 32'd0);
    if (bl[b]) begin
      model_bvalid = 1'b1;
      chk("b_latency", 32'(BVALID), 32'd1);
    end
  endtask

  // Holds BREADY low for 'hold' cycles, offering a new AW that must be ignored.
  task automatic b_accept(input int hold);
    if (hold > 0) begin
      AWVALID = 1'b1; AWADDR = 32'h0; AWID = 4'hF;
      repeat (hold) begin
        @(posedge clk); #1;
        chk("aw_ignored_in_b", 32'(AWREADY), 32'd0);
      end
      AWVALID = 1'b0;
    end
    BREADY = 1'b1;
    @(posedge clk); #1;
    BREADY = 1'b0;
    model_bvalid = 1'b0;
    chk("b_drop", 32'(BVALID), 32'd0);
  endtask

  task automatic sweep();
    for (int w = 0; w < 256; w++)
      chk("mem_word", dut.mem_q[w[7:0]],
          {exp_mem[4*w+3], exp_mem[4*w+2], exp_mem[4*w+1], exp_mem[4*w]});
  endtask

  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] bt, input int nb,
                           input logic [1:0] lit_resp, input int hold);
    logic [1:0] r;
    model_apply(id, addr, len, size, bt, nb, r);
    chk("model_resp", 32'(r), 32'(lit_resp));
    exp_bid   = id;
    exp_bresp = r;
    do_aw(id, addr, len, size, bt);
    for (int b = 0; b < nb; b++) do_w(b);
    b_accept(hold);
    if (mem_known) sweep();
  endtask

  // B channel compared against the model on every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("bvalid", 32'(BVALID), 32'(model_bvalid));
      if (model_bvalid) begin
        chk("bid", 32'(BID), 32'(exp_bid));
        chk("bresp", 32'(BRESP), 32'(exp_bresp));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] dummy;
    for (int i = 0; i < 1024; i++) exp_mem[i] = 8'h00;
    reset = 1'b1; AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; WLAST = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
    WID = '0; WDATA = '0; WSTRB = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(AWREADY), 32'd0);
    chk("rst_wready",  32'(WREADY),  32'd0);
    chk("rst_bvalid",  32'(BVALID),  32'd0);
    chk("rst_bid",     32'(BID),     32'd0);
    chk("rst_bresp",   32'(BRESP),   32'd0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Fill the whole memory so every word has a known value.
    for (int f = 0; f < 16; f++) begin
      set_beats(16, 32'hC000_0000 | 32'(f * 16), 4'hF, 4'd0);
      if (f == 15) mem_known = 1'b1;
      run_burst(4'd0, 32'(f * 64), 4'd15, 3'd2, 2'b01, 16, 2'b00, 0);
    end

    // INCR
    set_beats(4, 32'hA0, 4'hF, 4'd5);
    run_burst(4'd5, 32'h10, 4'd3, 3'd2, 2'b01, 4, 2'b00, 0);
    chk("incr_word4", dut.mem_q[8'd4], 32'h0000_00A0);
    chk("incr_word7", dut.mem_q[8'd7], 32'h0000_00A3);

    // WRAP: words 3,0,1,2
    set_beats(4, 32'hB0, 4'hF, 4'd6);
    run_burst(4'd6, 32'h0C, 4'd3, 3'd2, 2'b10, 4, 2'b00, 0);
    chk("wrap_word3", dut.mem_q[8'd3], 32'h0000_00B0);
    chk("wrap_word0", dut.mem_q[8'd0], 32'h0000_00B1);
    chk("wrap_word2", dut.mem_q[8'd2], 32'h0000_00B3);

    // FIXED narrow: only byte 0x21, last value wins
    set_beats(2, 32'h0, 4'b0010, 4'd7);
    bd[0] = 32'h0000_1100;
    bd[1] = 32'h0000_2200;
    run_burst(4'd7, 32'h21, 4'd1, 3'd0, 2'b00, 2, 2'b00, 0);
    chk("fixed_word8", dut.mem_q[8'd8], 32'hC000_2208);

    // Illegal AW variants and out-of-range address
    set_beats(2, 32'h55, 4'hF, 4'd1);
    run_burst(4'd1, 32'h40, 4'd1, 3'd2, 2'b11, 2, 2'b10, 0);
    set_beats(3, 32'h66, 4'hF, 4'd2);
    run_burst(4'd2, 32'h40, 4'd2, 3'd2, 2'b10, 3, 2'b10, 0);
    set_beats(1, 32'h77, 4'hF, 4'd4);
    run_burst(4'd4, 32'h400, 4'd0, 3'd2, 2'b01, 1, 2'b10, 0);

    // WID mismatch on beat 2, BREADY held low for 5 cycles
    set_beats(4, 32'hD0, 4'hF, 4'd3);
    bw[2] = 4'd4;
    run_burst(4'd3, 32'h80, 4'd3, 3'd2, 2'b01, 4, 2'b10, 5);
    chk("widerr_word20", dut.mem_q[8'h20], 32'h0000_00D0);
    chk("widerr_word22", dut.mem_q[8'h22], 32'hC000_0022);

    // Early WLAST (beat 1 of len 3) and late WLAST (beat 2 of len 1)
    set_beats(2, 32'h90, 4'hF, 4'd8);
    run_burst(4'd8, 32'hA0, 4'd3, 3'd2, 2'b01, 2, 2'b10, 0);
    set_beats(3, 32'h98, 4'hF, 4'd11);
    run_burst(4'd11, 32'h90, 4'd1, 3'd2, 2'b01, 3, 2'b10, 0);

    // Reset in W_WAIT after 2 of 4 beats
    set_beats(4, 32'hE0, 4'hF, 4'd9);
    model_apply(4'd9, 32'h100, 4'd3, 3'd2, 2'b01, 2, dummy);
    do_aw(4'd9, 32'h100, 4'd3, 3'd2, 2'b01);
    do_w(0);
    do_w(1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_awready", 32'(AWREADY), 32'd0);
    chk("midrst_wready",  32'(WREADY),  32'd0);
    chk("midrst_bvalid",  32'(BVALID),  32'd0);
    chk("midrst_bid",     32'(BID),     32'd0);
    chk("midrst_bresp",   32'(BRESP),   32'd0);
    reset = 1'b0;
    chk("midrst_word40", dut.mem_q[8'h40], 32'h0000_00E0);
    chk("midrst_word42", dut.mem_q[8'h42], 32'hC000_0042);
    set_beats(1, 32'hF0, 4'hF, 4'd10);
    run_burst(4'd10, 32'h200, 4'd0, 3'd2, 2'b01, 1, 2'b00, 0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
